// File: rtl/param_pipeline_reg_if.sv
// Bundle for the parametrised pipeline register: stage controls, input entry and output entry.
// BUSYWAIT is the only backpressure: an entry is taken on every rising edge with RESET=0, FLUSH=0, BUSYWAIT=0.
interface param_pipeline_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 12,
    parameter int DEPTH  = 1
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              BUSYWAIT;
    logic              FLUSH;
    logic              IN_VALID;
    logic [31:0]       IN_PC;
    logic [DATA_W-1:0] IN_DATA;
    logic [CTRL_W-1:0] IN_CTRL;
    logic              OUT_VALID;
    logic [31:0]       OUT_PC;
    logic [DATA_W-1:0] OUT_DATA;
    logic [CTRL_W-1:0] OUT_CTRL;
    logic [OCC_W-1:0]  OCCUPANCY;

    modport master (
        output BUSYWAIT, FLUSH, IN_VALID, IN_PC, IN_DATA, IN_CTRL,
        input  OUT_VALID, OUT_PC, OUT_DATA, OUT_CTRL, OCCUPANCY
    );

    modport slave (
        input  BUSYWAIT, FLUSH, IN_VALID, IN_PC, IN_DATA, IN_CTRL,
        output OUT_VALID, OUT_PC, OUT_DATA, OUT_CTRL, OCCUPANCY
    );
endinterface

// File: rtl/param_pipeline_reg.sv
// DEPTH-stage pipeline register carrying {valid, PC, payload, control} with stall, flush and occupancy.
// Optional stall counter output STALL_CNT is built when PIPE_REG_STALL_CNT_EN is defined.
module param_pipeline_reg #(
    parameter int          DATA_W = 96,
    parameter int          CTRL_W = 12,
    parameter int          DEPTH  = 1,
    parameter logic [31:0] PC_RST = 32'hFFFFFFFC
) (
    input  logic               CLK,
    input  logic               RESET,
`ifdef PIPE_REG_STALL_CNT_EN
    output logic [15:0]        STALL_CNT,
`endif
    param_pipeline_reg_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][31:0]       pc_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
    logic [OCC_W-1:0]             occ_q;
    logic [OCC_W-1:0]             occ_next;

    // Never exceeds DEPTH: a full pipe always has a valid last stage leaving.
    always_comb begin
        occ_next = occ_q + OCC_W'(bus.IN_VALID) - OCC_W'(valid_q[DEPTH-1]);
    end

    always_ff @(posedge CLK) begin
        if (RESET || bus.FLUSH) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                pc_q[i]    <= PC_RST;
                data_q[i]  <= '0;
                ctrl_q[i]  <= '0;
            end
            occ_q <= '0;
        end else if (!bus.BUSYWAIT) begin
            if (bus.IN_VALID) begin
                valid_q[0] <= 1'b1;
                pc_q[0]    <= bus.IN_PC;
                data_q[0]  <= bus.IN_DATA;
                ctrl_q[0]  <= bus.IN_CTRL;
            end else begin
                valid_q[0] <= 1'b0;
                pc_q[0]    <= PC_RST;
                data_q[0]  <= '0;
                ctrl_q[0]  <= '0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                pc_q[i]    <= pc_q[i-1];
                data_q[i]  <= data_q[i-1];
                ctrl_q[i]  <= ctrl_q[i-1];
            end
            occ_q <= occ_next;
        end
    end

`ifdef PIPE_REG_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Flush edges are not stalls even when BUSYWAIT is high; only RESET clears.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
        end else if (!bus.FLUSH && bus.BUSYWAIT && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

    assign bus.OUT_VALID = valid_q[DEPTH-1];
    assign bus.OUT_PC    = pc_q[DEPTH-1];
    assign bus.OUT_DATA  = data_q[DEPTH-1];
    // Invalid stages can never raise downstream write enables.
    assign bus.OUT_CTRL  = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
    assign bus.OCCUPANCY = occ_q;
endmodule
